// File: rtl/oam_dma_if.sv
// Bus_if: shared byte bus between the CPU/MMU, the DMA initiator and memory responders.
interface Bus_if;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        read_en;
    logic        write_en;
    modport master (output addr, wdata, read_en, write_en, input rdata);
    modport slave  (input addr, wdata, read_en, write_en, output rdata);
endinterface

// File: rtl/oam_dma.sv
// oam_dma: FF46-triggered 160-byte copy from {FF46,8'h00} into OAM, one byte per M-cycle tick.
// Define OAM_DMA_SRC_CLAMP_EN to fold E0..FF source pages down by 8'h20 (echo/WRAM mirror).
module oam_dma #(
    parameter int unsigned OAM_LEN     = 160,
    parameter int unsigned START_DELAY = 1,
    parameter logic [15:0] REG_ADDR    = 16'hFF46
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    Bus_if.slave       cpu_bus,
    Bus_if.master      bus,
    output logic       oam_we,
    output logic [7:0] oam_addr,
    output logic [7:0] oam_wdata,
    output logic       active
);
    typedef enum logic [1:0] {IDLE, START, XFER} state_t;

    state_t     state_q, state_d;
    logic [7:0] src_hi_q, src_hi_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] delay_cnt_q, delay_cnt_d;
    logic [7:0] src_eff;
    logic       reg_wr;
    logic       xfer;
    logic       delay_done;
    logic       last_byte;

    assign reg_wr     = cpu_bus.write_en && cpu_bus.addr == REG_ADDR;
    assign xfer       = state_q == XFER;
    assign delay_done = {24'd0, delay_cnt_q} + 32'd1 >= START_DELAY;
    assign last_byte  = idx_q == 8'(OAM_LEN - 1);

`ifdef OAM_DMA_SRC_CLAMP_EN
    assign src_eff = src_hi_q >= 8'hE0 ? src_hi_q - 8'h20 : src_hi_q;
`else
    assign src_eff = src_hi_q;
`endif

    // A register write always wins, restarting the copy even mid-transfer.
    always_comb begin
        state_d     = state_q;
        src_hi_d    = src_hi_q;
        idx_d       = idx_q;
        delay_cnt_d = delay_cnt_q;
        if (reg_wr) begin
            state_d     = START;
            src_hi_d    = cpu_bus.wdata;
            idx_d       = 8'd0;
            delay_cnt_d = 8'd0;
        end else if (tick && state_q == START) begin
            state_d     = delay_done ? XFER : START;
            delay_cnt_d = delay_done ? 8'd0 : delay_cnt_q + 8'd1;
            idx_d       = 8'd0;
        end else if (tick && xfer) begin
            state_d = last_byte ? IDLE : XFER;
            idx_d   = last_byte ? 8'd0 : idx_q + 8'd1;
        end
    end

    always_comb begin
        bus.addr      = xfer ? {src_eff, idx_q} : 16'h0000;
        bus.read_en   = xfer;
        bus.write_en  = 1'b0;
        bus.wdata     = 8'h00;
        oam_we        = xfer && tick && !reg_wr && !reset;
        oam_addr      = xfer ? idx_q : 8'h00;
        oam_wdata     = xfer ? bus.rdata : 8'h00;
        active        = xfer;
        cpu_bus.rdata = cpu_bus.read_en && cpu_bus.addr == REG_ADDR ? src_hi_q : 8'hFF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            src_hi_q    <= 8'hFF;
            idx_q       <= 8'd0;
            delay_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            src_hi_q    <= src_hi_d;
            idx_q       <= idx_d;
            delay_cnt_q <= delay_cnt_d;
        end
    end
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed vectors and hand-built transfer sequences for oam_dma.
module tb_oam_dma;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       oam_we;
    logic [7:0] oam_addr, oam_wdata;
    logic       active;
    logic [7:0] mem [0:65535];
    int         total = 0;
    int         bad = 0;
    int         viol = 0;
    logic [7:0] q_addr[$];
    logic [7:0] q_data[$];
    logic       s_we, s_bwe;
    logic [7:0] s_addr, s_data;
    logic [15:0] s_baddr;

    Bus_if cpu_bus();
    Bus_if bus();

    oam_dma dut (
        .clk(clk), .reset(reset), .tick(tick), .cpu_bus(cpu_bus), .bus(bus),
        .oam_we(oam_we), .oam_addr(oam_addr), .oam_wdata(oam_wdata), .active(active)
    );

    always #5 clk = ~clk;
    assign bus.rdata = mem[bus.addr];

    always @(posedge clk) begin
        if (oam_we) begin
            q_addr.push_back(oam_addr);
            q_data.push_back(oam_wdata);
            if (!tick) viol++;
        end
    end

    typedef struct {
        logic        we;
        logic        re;
        logic [15:0] addr;
        logic [7:0]  wd;
        logic [7:0]  exp_rd;
        logic        exp_act;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string n, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic tick_cyc();
        tick = 1'b1;
        #1;
        s_we = oam_we;
        s_addr = oam_addr;
        s_data = oam_wdata;
        s_baddr = bus.addr;
        s_bwe = bus.write_en;
        cyc();
        tick = 1'b0;
        cyc();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick_cyc();
    endtask

    task automatic wr46(input logic [7:0] v);
        cpu_bus.write_en = 1'b1;
        cpu_bus.addr = 16'hFF46;
        cpu_bus.wdata = v;
        cyc();
        cpu_bus.write_en = 1'b0;
    endtask

    task automatic rd46(input string n, input logic [7:0] e);
        cpu_bus.read_en = 1'b1;
        cpu_bus.addr = 16'hFF46;
        #1;
        chk(n, int'(cpu_bus.rdata), int'(e));
        cpu_bus.read_en = 1'b0;
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
        viol = 0;
    endtask

    initial begin
        int m;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 160; i++) begin
            mem[16'hC000 + i] = 8'(i) ^ 8'h5A;
            mem[16'hD000 + i] = 8'(i) ^ 8'hC3;
        end
        mem[16'hDE00] = 8'hA5;
        mem[16'hFE00] = 8'h77;
        cpu_bus.write_en = 1'b0;
        cpu_bus.read_en = 1'b0;
        cpu_bus.addr = 16'h0000;
        cpu_bus.wdata = 8'h00;
        vecs[0] = '{1'b0, 1'b1, 16'hFF46, 8'h00, 8'hFF, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 16'hFF47, 8'h00, 8'hFF, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 16'hFF47, 8'h12, 8'hFF, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 16'hFF46, 8'h00, 8'hFF, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 16'hFF46, 8'hC0, 8'hFF, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 16'hFF46, 8'h00, 8'hC0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 16'hFF45, 8'h00, 8'hFF, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 16'hFF46, 8'h3A, 8'hC0, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 16'hFF46, 8'h00, 8'h3A, 1'b0};

        do_reset();
        chk("rst_active", active, 0);
        chk("rst_we", oam_we, 0);
        chk("rst_baddr", bus.addr, 0);
        chk("rst_bre", bus.read_en, 0);
        chk("rst_bwe", bus.write_en, 0);
        rd46("rst_ff46", 8'hFF);
        clear_log();
        m = 0;
        for (int i = 0; i < 20; i++) begin
            tick_cyc();
            if (active) m++;
        end
        chk("idle_strobes", q_addr.size(), 0);
        chk("idle_active", m, 0);

        for (int i = 0; i < 9; i++) begin
            cpu_bus.write_en = vecs[i].we;
            cpu_bus.read_en = vecs[i].re;
            cpu_bus.addr = vecs[i].addr;
            cpu_bus.wdata = vecs[i].wd;
            #1;
            chk($sformatf("vec%0d_rd", i), cpu_bus.rdata, vecs[i].exp_rd);
            chk($sformatf("vec%0d_act", i), active, vecs[i].exp_act);
            cyc();
            cpu_bus.write_en = 1'b0;
            cpu_bus.read_en = 1'b0;
        end
        do_reset();

        clear_log();
        wr46(8'hC0);
        tick_cyc();
        chk("t2_tick1_we", s_we, 0);
        tick_cyc();
        chk("t2_tick2_we", s_we, 1);
        chk("t2_addr0", s_addr, 0);
        chk("t2_data0", s_data, 8'h5A);
        chk("t2_baddr0", s_baddr, 16'hC000);
        chk("t2_bwe", s_bwe, 0);
        ticks(158);
        chk("t2_active_last", active, 1);
        tick_cyc();
        chk("t2_active_done", active, 0);
        chk("t2_strobes", q_addr.size(), 160);
        m = 0;
        for (int i = 0; i < q_addr.size() && i < 160; i++)
            if (q_addr[i] != 8'(i) || q_data[i] != (8'(i) ^ 8'h5A)) m++;
        chk("t2_seq", m, 0);
        chk("t2_viol", viol, 0);
        rd46("t2_ff46", 8'hC0);

        clear_log();
        wr46(8'hC0);
        ticks(51);
        wr46(8'hD0);
        tick_cyc();
        chk("t3_delay_we", s_we, 0);
        ticks(160);
        chk("t3_strobes", q_addr.size(), 210);
        m = 0;
        for (int i = 0; i < q_addr.size() && i < 210; i++) begin
            if (i < 50) begin
                if (q_addr[i] != 8'(i) || q_data[i] != (8'(i) ^ 8'h5A)) m++;
            end else if (q_addr[i] != 8'(i - 50) || q_data[i] != (8'(i - 50) ^ 8'hC3)) m++;
        end
        chk("t3_seq", m, 0);
        chk("t3_active", active, 0);

        clear_log();
        wr46(8'hC0);
        ticks(81);
        chk("t4_active_pre", active, 1);
        reset = 1'b1;
        tick = 1'b1;
        #1;
        chk("t4_we_on_rst", oam_we, 0);
        cyc();
        reset = 1'b0;
        tick = 1'b0;
        chk("t4_active", active, 0);
        chk("t4_we", oam_we, 0);
        ticks(20);
        chk("t4_strobes", q_addr.size(), 80);
        rd46("t4_ff46", 8'hFF);

        clear_log();
        wr46(8'hC0);
        ticks(11);
        cpu_bus.write_en = 1'b1;
        cpu_bus.addr = 16'hFF46;
        cpu_bus.wdata = 8'hD0;
        tick = 1'b1;
        #1;
        chk("t5_we_coinc", oam_we, 0);
        cyc();
        cpu_bus.write_en = 1'b0;
        tick = 1'b0;
        chk("t5_active", active, 0);
        tick_cyc();
        chk("t5_tick1_we", s_we, 0);
        tick_cyc();
        chk("t5_tick2_we", s_we, 1);
        chk("t5_addr0", s_addr, 0);
        chk("t5_data0", s_data, 8'hC3);
        ticks(159);
        chk("t5_strobes", q_addr.size(), 170);
        chk("t5_viol", viol, 0);

        clear_log();
        wr46(8'hFE);
        tick_cyc();
        tick_cyc();
`ifdef OAM_DMA_SRC_CLAMP_EN
        chk("t6_baddr", s_baddr, 16'hDE00);
        chk("t6_data", s_data, 8'hA5);
`else
        chk("t6_baddr", s_baddr, 16'hFE00);
        chk("t6_data", s_data, 8'h77);
`endif
        rd46("t6_ff46", 8'hFE);
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
